// File: rtl/pc_ctrl.sv
// pc_ctrl: control-side partner of the program counter.
// Sequences the start-address load after reset/restart, resolves BZ/JMP
// instructions from fetch against a registered zero flag, and flushes the
// fetch slots that follow a taken branch.
// Optional feature macro: PC_CTRL_TAKEN_CNT_EN (taken-branch counter on
// taken_cnt_o; tied to zero when undefined).
// Handshake: instr_valid_i qualifies instr_i for exactly the cycle it is high;
// there is no back-pressure, and instructions presented outside RUN are dropped.
module pc_ctrl #(
    parameter logic [7:0] START_ADDR   = 8'h00,
    parameter int         START_CYCLES = 2,
    parameter int         FLUSH_CYCLES = 2
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic        restart_i,
    input  logic        instr_valid_i,
    input  logic [8:0]  instr_i,
    input  logic        flag_we_i,
    input  logic        flag_d_i,
    output logic        start_o,
    output logic [7:0]  startadd_o,
    output logic        branchf_o,
    output logic        branchb_o,
    output logic [7:0]  target_o,
    output logic        flush_o,
    output logic        zero_o,
    output logic [15:0] taken_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    // Counters are loaded with cycles-1 and the state ends when they hit 0.
    localparam logic [3:0] START_LOAD = 4'(START_CYCLES - 1);
    localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES == 0) ? 4'd0 : 4'(FLUSH_CYCLES - 1);
    localparam logic       FLUSH_EN   = (FLUSH_CYCLES != 0);

    // state_q is the debug-visible FSM state for checkers.
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic       is_jmp, is_bz, restart_go, taken;
    logic       start_d, flush_d, branchf_d, branchb_d, zero_d;
    logic [7:0] target_d;

    // Branch decode: restart always wins over a branch in the same cycle.
    always_comb begin
        is_jmp     = (instr_i[8:6] == 3'b111);
        is_bz      = (instr_i[8:6] == 3'b110);
        restart_go = restart_i && (state_q != IDLE);
        taken      = (state_q == RUN) && instr_valid_i && !restart_go &&
                     (is_jmp || (is_bz && zero_o));
    end

    // State register with the shared start/flush down-counter.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                state_d = START;
                cnt_d   = START_LOAD;
            end
            START: begin
                if (cnt_q == 4'd0) state_d = RUN;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RUN: begin
                if (taken && FLUSH_EN) begin
                    state_d = FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (cnt_q == 4'd0) state_d = RUN;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        if (restart_go) begin
            state_d = START;
            cnt_d   = START_LOAD;
        end
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        start_d   = (state_d == START);
        flush_d   = (state_d == FLUSH);
        branchf_d = taken && !instr_i[5];
        branchb_d = taken && instr_i[5];
        target_d  = taken ? {3'b000, instr_i[4:0]} : target_o;
        zero_d    = (flag_we_i && (state_q != IDLE)) ? flag_d_i : zero_o;
    end

    // Output registers; nothing reaches an output combinationally.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            start_o    <= 1'b0;
            startadd_o <= START_ADDR;
            branchf_o  <= 1'b0;
            branchb_o  <= 1'b0;
            target_o   <= 8'h00;
            flush_o    <= 1'b0;
            zero_o     <= 1'b0;
        end else begin
            start_o    <= start_d;
            startadd_o <= START_ADDR;
            branchf_o  <= branchf_d;
            branchb_o  <= branchb_d;
            target_o   <= target_d;
            flush_o    <= flush_d;
            zero_o     <= zero_d;
        end
    end

`ifdef PC_CTRL_TAKEN_CNT_EN
    logic [15:0] taken_cnt_q;

    // Taken-branch counter, wraps naturally; only reset clears it.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i)  taken_cnt_q <= 16'h0000;
        else if (taken)  taken_cnt_q <= taken_cnt_q + 16'd1;
    end

    assign taken_cnt_o = taken_cnt_q;
`else
    assign taken_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed test-plan steps followed by randomized traffic,
// every cycle compared against a cycle-count model of the controller.
module tb_pc_ctrl;

    localparam int START_CYCLES = 2;
    localparam int FLUSH_CYCLES = 2;

    logic        clock_i;
    logic        reset_n_i;
    logic        restart_i;
    logic        instr_valid_i;
    logic [8:0]  instr_i;
    logic        flag_we_i;
    logic        flag_d_i;
    logic        start_o;
    logic [7:0]  startadd_o;
    logic        branchf_o;
    logic        branchb_o;
    logic [7:0]  target_o;
    logic        flush_o;
    logic        zero_o;
    logic [15:0] taken_cnt_o;

    int total = 0;
    int bad   = 0;

    // Reference model: remaining start/flush cycles, flag, target, count.
    logic        m_idle;
    int          m_start;
    int          m_flush;
    logic        m_zero;
    logic [7:0]  m_target;
    logic [15:0] m_cnt;
    logic        m_bf;
    logic        m_bb;

    pc_ctrl #(
        .START_ADDR   (8'h00),
        .START_CYCLES (START_CYCLES),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clock_i       (clock_i),
        .reset_n_i     (reset_n_i),
        .restart_i     (restart_i),
        .instr_valid_i (instr_valid_i),
        .instr_i       (instr_i),
        .flag_we_i     (flag_we_i),
        .flag_d_i      (flag_d_i),
        .start_o       (start_o),
        .startadd_o    (startadd_o),
        .branchf_o     (branchf_o),
        .branchb_o     (branchb_o),
        .target_o      (target_o),
        .flush_o       (flush_o),
        .zero_o        (zero_o),
        .taken_cnt_o   (taken_cnt_o)
    );

    // Clock: posedges at 5, 15, 25, ...
    initial begin
        clock_i = 1'b0;
        forever #5 clock_i = ~clock_i;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [15:0] exp_cnt;
`ifdef PC_CTRL_TAKEN_CNT_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = 16'h0000;
`endif
        chk({tag, "/start"},    16'(start_o),    16'(m_start > 0));
        chk({tag, "/startadd"}, 16'(startadd_o), 16'h0000);
        chk({tag, "/branchf"},  16'(branchf_o),  16'(m_bf));
        chk({tag, "/branchb"},  16'(branchb_o),  16'(m_bb));
        chk({tag, "/target"},   16'(target_o),   16'(m_target));
        chk({tag, "/flush"},    16'(flush_o),    16'(m_flush > 0));
        chk({tag, "/zero"},     16'(zero_o),     16'(m_zero));
        chk({tag, "/cnt"},      taken_cnt_o,     exp_cnt);
    endtask

    task automatic model_reset();
        m_idle   = 1'b1;
        m_start  = 0;
        m_flush  = 0;
        m_zero   = 1'b0;
        m_target = 8'h00;
        m_cnt    = 16'h0000;
        m_bf     = 1'b0;
        m_bb     = 1'b0;
    endtask

    // Advance the model with the inputs present now, then clock and compare.
    task automatic tick(input string tag);
        logic run, rs, tk, jmp, bz;
        run = !m_idle && (m_start == 0) && (m_flush == 0);
        rs  = restart_i && !m_idle;
        jmp = (instr_i[8:6] == 3'b111);
        bz  = (instr_i[8:6] == 3'b110);
        tk  = run && instr_valid_i && (jmp || (bz && m_zero)) && !rs;
        m_bf = tk && !instr_i[5];
        m_bb = tk && instr_i[5];
        if (tk) begin
            m_target = {3'b000, instr_i[4:0]};
            m_cnt    = m_cnt + 16'd1;
        end
        if (!m_idle && flag_we_i) m_zero = flag_d_i;
        if (m_idle) begin
            m_idle  = 1'b0;
            m_start = START_CYCLES;
        end else if (rs) begin
            m_start = START_CYCLES;
            m_flush = 0;
        end else if (m_start > 0) begin
            m_start--;
        end else if (m_flush > 0) begin
            m_flush--;
        end else if (tk) begin
            m_flush = FLUSH_CYCLES;
        end
        @(posedge clock_i);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input string tag);
        reset_n_i = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        chk({tag, "/cnt0"}, taken_cnt_o, 16'h0000);
        #1;
        reset_n_i = 1'b1;
    endtask

    task automatic quiet();
        restart_i     = 1'b0;
        instr_valid_i = 1'b0;
        instr_i       = 9'h000;
        flag_we_i     = 1'b0;
        flag_d_i      = 1'b0;
    endtask

    initial begin
        quiet();
        reset_n_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clock_i);
        #1;
        check_all("reset");
        reset_n_i = 1'b1;

        // Start sequence: start_o high for the two cycles after IDLE.
        tick("idle_to_start");
        chk("start_c1", 16'(start_o), 16'h1);
        tick("start2");
        chk("start_c2", 16'(start_o), 16'h1);
        tick("start_end");
        chk("start_done", 16'(start_o), 16'h0);

        // Forward JMP, then a JMP during flush is ignored.
        instr_i = 9'b111_0_00101; instr_valid_i = 1'b1;
        tick("jmp_fwd");
        chk("jmp_bf", 16'(branchf_o), 16'h1);
        chk("jmp_target", 16'(target_o), 16'h0005);
        chk("jmp_flush", 16'(flush_o), 16'h1);
        tick("flush_jmp");
        chk("flush_nopulse", 16'(branchf_o), 16'h0);
        quiet();
        tick("flush_end");

        // BZ backward with flag set, then with flag cleared.
        flag_we_i = 1'b1; flag_d_i = 1'b1;
        tick("flag_set");
        quiet();
        instr_i = 9'b110_1_00011; instr_valid_i = 1'b1;
        tick("bz_taken");
        chk("bz_bb", 16'(branchb_o), 16'h1);
        chk("bz_target", 16'(target_o), 16'h0003);
        quiet();
        tick("bz_flush1");
        tick("bz_flush2");
        flag_we_i = 1'b1; flag_d_i = 1'b0;
        tick("flag_clr");
        quiet();
        instr_i = 9'b110_1_00011; instr_valid_i = 1'b1;
        tick("bz_not_taken");
        chk("bz_nt_bb", 16'(branchb_o), 16'h0);
        chk("bz_nt_target", 16'(target_o), 16'h0003);

        // BZ in the same cycle as the flag write uses the old flag.
        flag_we_i = 1'b1; flag_d_i = 1'b1;
        tick("bz_same_cycle");
        chk("bz_old_flag", 16'(branchb_o), 16'h0);
        flag_we_i = 1'b0;
        tick("bz_next_cycle");
        chk("bz_new_flag", 16'(branchb_o), 16'h1);
        quiet();
        tick("bz2_flush1");
        tick("bz2_flush2");

        // Restart together with a valid JMP: restart wins.
        restart_i = 1'b1; instr_i = 9'b111_0_01010; instr_valid_i = 1'b1;
        tick("restart_jmp");
        chk("restart_nobf", 16'(branchf_o), 16'h0);
        chk("restart_start", 16'(start_o), 16'h1);
        chk("restart_zero", 16'(zero_o), 16'h1);
        quiet();
        tick("restart_s2");
        tick("restart_end");

        // Taken branch, then reset in the middle of the flush.
        instr_i = 9'b111_1_11111; instr_valid_i = 1'b1;
        tick("jmp_back");
        quiet();
        chk("mid_flush", 16'(flush_o), 16'h1);
        async_reset("reset_mid_flush");

        // Randomized traffic with occasional restarts and resets.
        for (int i = 0; i < 600; i++) begin
            restart_i     = ($urandom_range(0, 39) == 0);
            instr_valid_i = $urandom_range(0, 1) == 1;
            instr_i       = 9'($urandom);
            if ($urandom_range(0, 1) == 1) instr_i[8:7] = 2'b11;
            flag_we_i     = ($urandom_range(0, 3) == 0);
            flag_d_i      = $urandom_range(0, 1) == 1;
            tick("rand");
            if ($urandom_range(0, 149) == 0) begin
                quiet();
                async_reset("rand_reset");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
